// File: rtl/load_data_register.sv
// Memory-read data register for the multicycle MIPS CPU: captures bus readdata in the
// capture state (honouring waitrequest), formats it per load type and requests stalls.
module load_data_register #(
    parameter int DATA_WIDTH    = 32,
    parameter int STATE_WIDTH   = 3,
    parameter int CAPTURE_STATE = 3,
    localparam int NB           = DATA_WIDTH / 8,
    localparam int OW           = (NB > 1) ? $clog2(NB) : 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [STATE_WIDTH-1:0] state,
    input  logic                   read,
    input  logic                   waitrequest,
    input  logic [DATA_WIDTH-1:0]  readdata,
    input  logic [OW-1:0]          byte_offset,
    input  logic [2:0]             load_type,
    input  logic [DATA_WIDTH-1:0]  rt_old,
    output logic [DATA_WIDTH-1:0]  dr_readdata,
    output logic                   dr_valid,
    output logic                   stall
);

    typedef enum logic [1:0] {IDLE, WAIT, FULL} fsm_t;

    fsm_t                  fsm_reg, fsm_next;
    logic [DATA_WIDTH-1:0] dr_readdata_reg, fmt_next;
    logic                  capture;
    logic                  in_cap_state, cap;

    assign in_cap_state = (state == STATE_WIDTH'(CAPTURE_STATE));
    assign cap          = in_cap_state & read;

    // Byte lanes of the little-endian bus word
    logic [7:0] rd_bytes [NB];
    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_bytes
            assign rd_bytes[gi] = readdata[8*gi +: 8];
        end
    endgenerate

    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;
    logic [OW-1:0]         half_off, o_inv;
    logic [OW+2:0]         lwl_shift, lwr_shift;
    logic [DATA_WIDTH-1:0] ones;

    always_comb begin
        ones      = '1;
        byte_sel  = rd_bytes[byte_offset];
        half_off  = byte_offset & ~OW'(1);
        half_sel  = {rd_bytes[half_off | OW'(1)], rd_bytes[half_off]};
        o_inv     = OW'(NB - 1) - byte_offset;
        lwl_shift = {o_inv, 3'b000};
        lwr_shift = {byte_offset, 3'b000};
        case (load_type)
            3'd1:    fmt_next = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
            3'd2:    fmt_next = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
            3'd3:    fmt_next = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
            3'd4:    fmt_next = {{(DATA_WIDTH-16){1'b0}}, half_sel};
            // Unaligned word halves merge with the surviving bytes of rt
            3'd5:    fmt_next = (readdata << lwl_shift) | (rt_old & ~(ones << lwl_shift));
            3'd6:    fmt_next = (readdata >> lwr_shift) | (rt_old & ~(ones >> lwr_shift));
            default: fmt_next = readdata;
        endcase
    end

    always_comb begin
        fsm_next = fsm_reg;
        capture  = 1'b0;
        case (fsm_reg)
            IDLE: begin
                if (cap) begin
                    fsm_next = waitrequest ? WAIT : FULL;
                    capture  = !waitrequest;
                end
            end
            WAIT: begin
                if (!cap) begin
                    fsm_next = IDLE;
                end else if (!waitrequest) begin
                    fsm_next = FULL;
                    capture  = 1'b1;
                end
            end
            FULL: begin
                if (!in_cap_state)
                    fsm_next = IDLE;
            end
            default: fsm_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fsm_reg         <= IDLE;
            dr_readdata_reg <= '0;
        end else begin
            fsm_reg <= fsm_next;
            if (capture)
                dr_readdata_reg <= fmt_next;
        end
    end

    assign dr_readdata = dr_readdata_reg;
    assign dr_valid    = (fsm_reg == FULL);
    assign stall       = cap & waitrequest & (fsm_reg != FULL);

endmodule

// File: tb/tb_load_data_register.sv
// Table-driven bench for load_data_register with a scoreboard queue of expected captures.
module tb_load_data_register;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  state;
    logic        read;
    logic        waitrequest;
    logic [31:0] readdata;
    logic [1:0]  byte_offset;
    logic [2:0]  load_type;
    logic [31:0] rt_old;
    logic [31:0] dr_readdata;
    logic        dr_valid;
    logic        stall;

    load_data_register #(.DATA_WIDTH(32), .STATE_WIDTH(3), .CAPTURE_STATE(3)) dut (
        .clk(clk), .reset_n(reset_n), .state(state), .read(read),
        .waitrequest(waitrequest), .readdata(readdata), .byte_offset(byte_offset),
        .load_type(load_type), .rt_old(rt_old), .dr_readdata(dr_readdata),
        .dr_valid(dr_valid), .stall(stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  lt;
        logic [1:0]  off;
        logic [31:0] rd;
        logic [31:0] rt;
        int          wt;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs [15];
    logic [31:0] exp_q [$];
    logic [31:0] last_exp;
    logic [31:0] popped;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    task automatic idle_inputs();
        state       = 3'd0;
        read        = 1'b0;
        waitrequest = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // lt, off, readdata, rt_old, wait cycles, expected
        vecs[0]  = '{3'd0, 2'd0, 32'hDEADBEEF, 32'h0,        0, 32'hDEADBEEF};
        vecs[1]  = '{3'd1, 2'd2, 32'h00800000, 32'h0,        3, 32'hFFFFFF80};
        vecs[2]  = '{3'd2, 2'd2, 32'h00800000, 32'h0,        3, 32'h00000080};
        vecs[3]  = '{3'd3, 2'd3, 32'h80011234, 32'h0,        0, 32'hFFFF8001};
        vecs[4]  = '{3'd4, 2'd3, 32'h80011234, 32'h0,        1, 32'h00008001};
        vecs[5]  = '{3'd5, 2'd1, 32'hAABBCCDD, 32'h11223344, 0, 32'hCCDD3344};
        vecs[6]  = '{3'd6, 2'd1, 32'hAABBCCDD, 32'h11223344, 2, 32'h11AABBCC};
        vecs[7]  = '{3'd5, 2'd3, 32'hAABBCCDD, 32'h11223344, 0, 32'hAABBCCDD};
        vecs[8]  = '{3'd5, 2'd0, 32'hAABBCCDD, 32'h11223344, 0, 32'hDD223344};
        vecs[9]  = '{3'd6, 2'd0, 32'hAABBCCDD, 32'h11223344, 0, 32'hAABBCCDD};
        vecs[10] = '{3'd6, 2'd3, 32'hAABBCCDD, 32'h11223344, 1, 32'h112233AA};
        vecs[11] = '{3'd1, 2'd1, 32'hAABBCCDD, 32'h0,        0, 32'hFFFFFFCC};
        vecs[12] = '{3'd3, 2'd1, 32'h00017FFE, 32'h0,        0, 32'h00007FFE};
        vecs[13] = '{3'd7, 2'd2, 32'h12345678, 32'h0,        0, 32'h12345678};
        vecs[14] = '{3'd1, 2'd3, 32'hAABBCCDD, 32'h0,        1, 32'hFFFFFFAA};

        reset_n = 1'b0;
        idle_inputs();
        readdata = 32'h0; byte_offset = 2'd0; load_type = 3'd0; rt_old = 32'h0;
        last_exp = 32'h0;
        @(negedge clk); @(negedge clk);
        check("reset_data",  dr_readdata, 32'h0);
        check("reset_valid", {31'h0, dr_valid}, 32'h0);
        check("reset_stall", {31'h0, stall}, 32'h0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 15; v++) begin
            state = 3'd3; read = 1'b1;
            load_type = vecs[v].lt; byte_offset = vecs[v].off; rt_old = vecs[v].rt;
            for (int i = 0; i < vecs[v].wt; i++) begin
                waitrequest = 1'b1;
                readdata = $urandom;
                #1 check($sformatf("v%0d_stall_wait%0d", v, i), {31'h0, stall}, 32'h1);
                @(negedge clk);
                check($sformatf("v%0d_valid_wait%0d", v, i), {31'h0, dr_valid}, 32'h0);
            end
            waitrequest = 1'b0;
            readdata = vecs[v].rd;
            #1 check($sformatf("v%0d_stall_cap", v), {31'h0, stall}, 32'h0);
            exp_q.push_back(vecs[v].exp);
            @(negedge clk);
            check($sformatf("v%0d_valid", v), {31'h0, dr_valid}, 32'h1);
            if (exp_q.size() == 0) begin
                check($sformatf("v%0d_queue", v), 32'h0, 32'h1);
            end else begin
                popped = exp_q.pop_front();
                check($sformatf("v%0d_data", v), dr_readdata, popped);
                last_exp = popped;
            end
            if (v < 3) begin
                // FULL with cap held and fresh bus data: no stall, no recapture
                waitrequest = 1'b1;
                readdata = ~vecs[v].rd;
                #1 check($sformatf("v%0d_full_stall", v), {31'h0, stall}, 32'h0);
                @(negedge clk);
                waitrequest = 1'b0;
                @(negedge clk);
                check($sformatf("v%0d_full_hold", v), dr_readdata, last_exp);
                check($sformatf("v%0d_full_valid", v), {31'h0, dr_valid}, 32'h1);
            end
            idle_inputs();
            @(negedge clk);
            check($sformatf("v%0d_release_valid", v), {31'h0, dr_valid}, 32'h0);
            check($sformatf("v%0d_release_data", v), dr_readdata, last_exp);
        end

        // Abort from WAIT: state leaves capture state with good data on the bus
        state = 3'd3; read = 1'b1; waitrequest = 1'b1; load_type = 3'd0;
        readdata = 32'h55555555;
        @(negedge clk); @(negedge clk);
        state = 3'd2; waitrequest = 1'b0;
        #1 check("abort_stall", {31'h0, stall}, 32'h0);
        @(negedge clk);
        check("abort_valid", {31'h0, dr_valid}, 32'h0);
        check("abort_data", dr_readdata, last_exp);
        idle_inputs();
        @(negedge clk);
        check("abort_after_data", dr_readdata, last_exp);

        // Async reset in the middle of WAIT
        state = 3'd3; read = 1'b1; waitrequest = 1'b1; readdata = 32'h66666666;
        @(negedge clk); @(negedge clk);
        #2 reset_n = 1'b0;
        #1 check("rst_wait_data", dr_readdata, 32'h0);
        check("rst_wait_valid", {31'h0, dr_valid}, 32'h0);
        check("rst_wait_stall", {31'h0, stall}, 32'h1);
        @(negedge clk);
        waitrequest = 1'b0;
        @(negedge clk);
        idle_inputs();
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_after_data", dr_readdata, 32'h0);
        check("rst_after_valid", {31'h0, dr_valid}, 32'h0);
        check("scoreboard_empty", exp_q.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
